// File: rtl/iir_mc_pkg.sv
// Shared constants and helpers for the multi-channel shift-add IIR filter.
// Widths up to MAXW bits are supported by the range-check helper.
package iir_mc_pkg;

    localparam int MAXW   = 32;
    localparam int W_DEF  = 15;
    localparam int CH_DEF = 4;
    localparam int SW_DEF = 4;

    function automatic int chw(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    localparam int CHW = chw(CH_DEF);

    typedef struct packed {
        logic above;
        logic below;
        logic ovf;
    } sat_t;

    // Classifies a sign-extended sum against the signed range of a w-bit word.
    function automatic sat_t sat_w(input logic signed [MAXW+1:0] sum, input int w);
        logic signed [MAXW+1:0] hi;
        logic signed [MAXW+1:0] lo;
        sat_t r;
        hi = ((MAXW+2)'(1) << (w - 1)) - (MAXW+2)'(1);
        lo = ~hi;
        r.above = (sum > hi);
        r.below = (sum < lo);
        r.ovf   = r.above || r.below;
        return r;
    endfunction

endpackage

// File: rtl/iir_mc_dp.sv
// Combinational datapath: gated arithmetic shifts of the channel state,
// three-input add at W+2 bits, then saturate or wrap back to W bits.
module iir_mc_dp
    import iir_mc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int SW = SW_DEF
) (
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] shift_a,
    input  logic [SW-1:0] shift_b,
    input  logic          sat_en,
    output logic [W-1:0]  result,
    output logic          ovf
);

    logic signed [W+1:0] y_ext;
    logic signed [W+1:0] x_ext;
    logic signed [W+1:0] term_a;
    logic signed [W+1:0] term_b;
    logic signed [W+1:0] sum;
    sat_t                sat;

    always_comb begin
        y_ext = {{2{y[W-1]}}, y};
        x_ext = {{2{x[W-1]}}, x};
        // if/else rather than ?: so the shifts stay arithmetic
        term_a = '0;
        if (shift_a != '0) begin
            term_a = y_ext >>> shift_a;
        end
        term_b = '0;
        if (shift_b != '0) begin
            term_b = y_ext >>> shift_b;
        end
        sum = x_ext + term_a + term_b;
        sat = sat_w((MAXW+2)'(sum), W);
        ovf = sat.ovf;
        if (sat_en && sat.above) begin
            result = {1'b0, {(W-1){1'b1}}};
        end else if (sat_en && sat.below) begin
            result = {1'b1, {(W-1){1'b0}}};
        end else begin
            result = sum[W-1:0];
        end
    end

endmodule

// File: rtl/iir_mc.sv
// Time-multiplexed first-order shift-add lowpass: per-channel state array,
// valid/ready input, single output register and sticky overflow flag.
module iir_mc
    import iir_mc_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CH = CH_DEF,
    parameter int SW = SW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [W-1:0]         s_data,
    input  logic [chw(CH)-1:0]   s_ch,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [W-1:0]         m_data,
    output logic [chw(CH)-1:0]   m_ch,
    input  logic [SW-1:0]        shift_a,
    input  logic [SW-1:0]        shift_b,
    input  logic                 sat_en,
    input  logic                 clr,
    output logic                 ovf
);

    localparam int CW = chw(CH);

    logic [W-1:0]  state_reg [CH];
    logic          m_valid_reg;
    logic [W-1:0]  m_data_reg;
    logic [CW-1:0] m_ch_reg;
    logic          ovf_reg;

    logic          accept;
    logic          in_range;
    logic [W-1:0]  y_ch;
    logic [W-1:0]  result;
    logic          dp_ovf;

    assign s_ready  = !m_valid_reg || m_ready;
    assign accept   = s_valid && s_ready;
    assign in_range = int'(s_ch) < CH;

    // A clear in the same cycle as an accept makes that sample see zero state.
    always_comb begin
        y_ch = '0;
        if (!clr && in_range) begin
            y_ch = state_reg[s_ch];
        end
    end

    iir_mc_dp #(
        .W  (W),
        .SW (SW)
    ) u_dp (
        .y       (y_ch),
        .x       (s_data),
        .shift_a (shift_a),
        .shift_b (shift_b),
        .sat_en  (sat_en),
        .result  (result),
        .ovf     (dp_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CH; i++) begin
                state_reg[i] <= '0;
            end
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_ch_reg    <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            if (clr) begin
                for (int i = 0; i < CH; i++) begin
                    state_reg[i] <= '0;
                end
                ovf_reg <= 1'b0;
            end
            if (accept && in_range) begin
                state_reg[s_ch] <= result;
                m_data_reg      <= result;
                m_ch_reg        <= s_ch;
                m_valid_reg     <= 1'b1;
                if (dp_ovf) begin
                    ovf_reg <= 1'b1;
                end
            end else if (m_valid_reg && m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_ch    = m_ch_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_iir_mc.sv
// Directed bench for iir_mc: main instance with 4 channels plus a 3-channel
// instance sharing the same stimulus to exercise out-of-range channel drops.
module tb_iir_mc;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic signed [14:0] s_data;
    logic [1:0]         s_ch;
    logic               m_valid;
    logic               m_ready;
    logic signed [14:0] m_data;
    logic [1:0]         m_ch;
    logic [3:0]         shift_a;
    logic [3:0]         shift_b;
    logic               sat_en;
    logic               clr;
    logic               ovf;

    logic               s_ready3;
    logic               m_valid3;
    logic signed [14:0] m_data3;
    logic [1:0]         m_ch3;
    logic               ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iir_mc #(.W(15), .CH(4), .SW(4)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_ch(m_ch), .shift_a(shift_a), .shift_b(shift_b),
        .sat_en(sat_en), .clr(clr), .ovf(ovf)
    );

    iir_mc #(.W(15), .CH(3), .SW(4)) dut3 (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready3),
        .s_data(s_data), .s_ch(s_ch), .m_valid(m_valid3), .m_ready(m_ready),
        .m_data(m_data3), .m_ch(m_ch3), .shift_a(shift_a), .shift_b(shift_b),
        .sat_en(sat_en), .clr(clr), .ovf(ovf3)
    );

    task automatic set_cfg(input logic [3:0] a, input logic [3:0] b, input logic sat);
        shift_a = a;
        shift_b = b;
        sat_en  = sat;
    endtask

    // Offer one sample, wait (bounded) for s_ready, then let it be accepted.
    task automatic send(input logic [1:0] ch, input int x, input logic do_clr);
        int wait_cycles;
        s_ch    = ch;
        s_data  = x[14:0];
        s_valid = 1'b1;
        clr     = do_clr;
        wait_cycles = 0;
        while (!s_ready && wait_cycles < 50) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout s_ready got %0b want 1 after %0d cycles", s_ready, wait_cycles);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        clr     = 1'b0;
        $display("txn ch=%0d x=%0d clr=%0b -> m_valid=%0b m_ch=%0d m_data=%0d ovf=%0b",
                 ch, x, do_clr, m_valid, m_ch, m_data, ovf);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        n_checks++; if (m_ch !== 2'd0) begin n_fail++; $display("FAIL reset_m_ch got %0d want 0", m_ch); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
    endtask

    task automatic test_impulse;
        int exp_y [4] = '{1000, 750, 562, 421};
        set_cfg(4'd1, 4'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send(2'd0, (i == 0) ? 1000 : 0, i == 0);
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL impulse_valid[%0d] got %0b want 1", i, m_valid); end
            n_checks++; if (m_data !== 15'(exp_y[i])) begin n_fail++; $display("FAIL impulse_data[%0d] got %0d want %0d", i, m_data, exp_y[i]); end
            n_checks++; if (m_ch !== 2'd0) begin n_fail++; $display("FAIL impulse_ch[%0d] got %0d want 0", i, m_ch); end
        end
    endtask

    task automatic test_step;
        int exp_y [4] = '{1000, 1750, 2312, 2734};
        set_cfg(4'd1, 4'd2, 1'b1);
        for (int i = 0; i < 40; i++) begin
            send(2'd1, 1000, i == 0);
            if (i < 4) begin
                n_checks++; if (m_data !== 15'(exp_y[i])) begin n_fail++; $display("FAIL step_data[%0d] got %0d want %0d", i, m_data, exp_y[i]); end
            end
        end
        n_checks++;
        if (int'(m_data) < 3980 || int'(m_data) > 4000) begin
            n_fail++; $display("FAIL step_final got %0d want 3980..4000", m_data);
        end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL step_ovf got %0b want 0", ovf); end
    endtask

    task automatic test_saturation;
        set_cfg(4'd1, 4'd2, 1'b1);
        send(2'd2, 16383, 1'b1);
        n_checks++; if (m_data !== 15'(16383)) begin n_fail++; $display("FAIL sat_pos1 got %0d want 16383", m_data); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_pos1_ovf got %0b want 0", ovf); end
        send(2'd2, 16383, 1'b0);
        n_checks++; if (m_data !== 15'(16383)) begin n_fail++; $display("FAIL sat_pos2 got %0d want 16383", m_data); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_pos2_ovf got %0b want 1", ovf); end
        send(2'd2, -16384, 1'b1);
        n_checks++; if (m_data !== 15'(-16384)) begin n_fail++; $display("FAIL sat_neg1 got %0d want -16384", m_data); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sat_neg1_ovf got %0b want 0", ovf); end
        send(2'd2, -16384, 1'b0);
        n_checks++; if (m_data !== 15'(-16384)) begin n_fail++; $display("FAIL sat_neg2 got %0d want -16384", m_data); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_neg2_ovf got %0b want 1", ovf); end
        set_cfg(4'd1, 4'd2, 1'b0);
        send(2'd2, 16383, 1'b1);
        n_checks++; if (m_data !== 15'(16383)) begin n_fail++; $display("FAIL wrap1 got %0d want 16383", m_data); end
        send(2'd2, 16383, 1'b0);
        n_checks++; if (m_data !== 15'(-4099)) begin n_fail++; $display("FAIL wrap2 got %0d want -4099", m_data); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL wrap2_ovf got %0b want 1", ovf); end
        // clear alone: ovf and states drop, output register keeps its data
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %0b want 0", ovf); end
        n_checks++; if (m_data !== 15'(-4099)) begin n_fail++; $display("FAIL clr_hold got %0d want -4099", m_data); end
        send(2'd2, 0, 1'b0);
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL clr_state got %0d want 0", m_data); end
    endtask

    task automatic test_interleave;
        logic [1:0] chs [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        int xs [7]    = '{1000, 0, 0, 0, 0, 0, 0};
        int exp_y [7] = '{1000, 0, 750, 0, 562, 0, 421};
        set_cfg(4'd1, 4'd2, 1'b1);
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_ch    = chs[i];
            s_data  = xs[i][14:0];
            clr     = (i == 0);
            @(posedge clk); #1;
            clr = 1'b0;
            $display("txn ch=%0d x=%0d -> m_valid=%0b m_ch=%0d m_data=%0d", chs[i], xs[i], m_valid, m_ch, m_data);
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL ilv_valid[%0d] got %0b want 1", i, m_valid); end
            n_checks++; if (m_ch !== chs[i]) begin n_fail++; $display("FAIL ilv_ch[%0d] got %0d want %0d", i, m_ch, chs[i]); end
            n_checks++; if (m_data !== 15'(exp_y[i])) begin n_fail++; $display("FAIL ilv_data[%0d] got %0d want %0d", i, m_data, exp_y[i]); end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        set_cfg(4'd1, 4'd2, 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        send(2'd2, 1000, 1'b1);
        n_checks++; if (m_data !== 15'd1000) begin n_fail++; $display("FAIL bp_first got %0d want 1000", m_data); end
        s_valid = 1'b1;
        s_ch    = 2'd2;
        s_data  = 15'd0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", i, s_ready); end
            @(posedge clk); #1;
            n_checks++; if (m_data !== 15'd1000 || m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %0d/%0b want 1000/1", i, m_data, m_valid); end
        end
        m_ready = 1'b1;
        #1;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0b want 1", s_ready); end
        @(posedge clk); #1;
        s_valid = 1'b0;
        $display("txn ch=2 x=0 (released) -> m_valid=%0b m_data=%0d", m_valid, m_data);
        n_checks++; if (m_data !== 15'd750 || m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got %0d/%0b want 750/1", m_data, m_valid); end
        @(posedge clk); #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", m_valid); end
        n_checks++; if (m_data !== 15'd750) begin n_fail++; $display("FAIL bp_data_hold got %0d want 750", m_data); end
        send(2'd2, 0, 1'b0);
        n_checks++; if (m_data !== 15'd562) begin n_fail++; $display("FAIL bp_third got %0d want 562", m_data); end
    endtask

    task automatic test_clr_step;
        set_cfg(4'd1, 4'd2, 1'b1);
        send(2'd3, 16383, 1'b1);
        send(2'd3, 16383, 1'b0);
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL clrstep_pre_ovf got %0b want 1", ovf); end
        send(2'd0, 1000, 1'b0);
        send(2'd0, 1000, 1'b0);
        n_checks++; if (m_data !== 15'd1750) begin n_fail++; $display("FAIL clrstep_pre got %0d want 1750", m_data); end
        send(2'd0, 1000, 1'b1);
        n_checks++; if (m_data !== 15'd1000) begin n_fail++; $display("FAIL clrstep_same got %0d want 1000", m_data); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clrstep_ovf got %0b want 0", ovf); end
        send(2'd0, 1000, 1'b0);
        n_checks++; if (m_data !== 15'd1750) begin n_fail++; $display("FAIL clrstep_next got %0d want 1750", m_data); end
        send(2'd3, 0, 1'b0);
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL clrstep_other got %0d want 0", m_data); end
    endtask

    task automatic test_shift_bounds;
        set_cfg(4'd0, 4'd0, 1'b1);
        send(2'd3, 1234, 1'b1);
        n_checks++; if (m_data !== 15'd1234) begin n_fail++; $display("FAIL noshift1 got %0d want 1234", m_data); end
        send(2'd3, 1234, 1'b0);
        n_checks++; if (m_data !== 15'd1234) begin n_fail++; $display("FAIL noshift2 got %0d want 1234", m_data); end
        send(2'd3, -5, 1'b0);
        n_checks++; if (m_data !== 15'(-5)) begin n_fail++; $display("FAIL noshift3 got %0d want -5", m_data); end
        set_cfg(4'd15, 4'd0, 1'b1);
        send(2'd0, -100, 1'b1);
        n_checks++; if (m_data !== 15'(-100)) begin n_fail++; $display("FAIL bigshift1 got %0d want -100", m_data); end
        send(2'd0, 0, 1'b0);
        n_checks++; if (m_data !== 15'(-1)) begin n_fail++; $display("FAIL bigshift_neg got %0d want -1", m_data); end
        send(2'd0, 100, 1'b0);
        n_checks++; if (m_data !== 15'd99) begin n_fail++; $display("FAIL bigshift2 got %0d want 99", m_data); end
        set_cfg(4'd0, 4'd15, 1'b1);
        send(2'd0, 0, 1'b0);
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL bigshift_pos got %0d want 0", m_data); end
    endtask

    task automatic test_reset_mid;
        set_cfg(4'd1, 4'd2, 1'b1);
        m_ready = 1'b1;
        send(2'd1, 16383, 1'b1);
        send(2'd1, 16383, 1'b0);
        @(posedge clk); #1;
        m_ready = 1'b0;
        send(2'd0, 1000, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got %0b/%0b want 1/1", m_valid, ovf); end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", m_valid); end
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL rmid_data got %0d want 0", m_data); end
        n_checks++; if (m_ch !== 2'd0) begin n_fail++; $display("FAIL rmid_ch got %0d want 0", m_ch); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf got %0b want 0", ovf); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %0b want 1", s_ready); end
        m_ready = 1'b1;
        send(2'd0, 0, 1'b0);
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL rmid_state0 got %0d want 0", m_data); end
        send(2'd1, 0, 1'b0);
        n_checks++; if (m_data !== 15'd0) begin n_fail++; $display("FAIL rmid_state1 got %0d want 0", m_data); end
    endtask

    task automatic test_out_of_range;
        set_cfg(4'd1, 4'd2, 1'b1);
        m_ready = 1'b1;
        send(2'd0, 1000, 1'b1);
        n_checks++; if (m_data3 !== 15'd1000) begin n_fail++; $display("FAIL oor_base got %0d want 1000", m_data3); end
        send(2'd3, 500, 1'b0);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 15'd500 || m_ch !== 2'd3) begin n_fail++; $display("FAIL oor_ch4 got %0b/%0d/%0d want 1/500/3", m_valid, m_data, m_ch); end
        n_checks++; if (m_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor_drop_valid got %0b want 0", m_valid3); end
        n_checks++; if (m_data3 !== 15'd1000 || m_ch3 !== 2'd0) begin n_fail++; $display("FAIL oor_drop_hold got %0d/%0d want 1000/0", m_data3, m_ch3); end
        send(2'd0, 0, 1'b0);
        n_checks++; if (m_valid3 !== 1'b1 || m_data3 !== 15'd750) begin n_fail++; $display("FAIL oor_after got %0b/%0d want 1/750", m_valid3, m_data3); end
        n_checks++; if (ovf3 !== 1'b0) begin n_fail++; $display("FAIL oor_ovf got %0b want 0", ovf3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_ch    = '0;
        m_ready = 1'b1;
        shift_a = 4'd1;
        shift_b = 4'd2;
        sat_en  = 1'b1;
        clr     = 1'b0;
        test_reset;
        test_impulse;
        test_step;
        test_saturation;
        test_interleave;
        test_backpressure;
        test_clr_step;
        test_shift_bounds;
        test_reset_mid;
        test_out_of_range;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
